// File: rtl/timer_bank.sv
// Bank of memory-mapped down-counting timers with per-channel masked, sticky W1C interrupts.
// timer_ch holds one channel's registers and FSM; timer_bank decodes the bus window and muxes reads.

module timer_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ctrl_we_i,
    input  logic             preset_we_i,
    input  logic             status_we_i,
    input  logic [2:0]       ctrl_wd_i,     // {im, mode, en}
    input  logic             w1c_i,
    input  logic [CNT_W-1:0] preset_wd_i,
    output logic             en_o,
    output logic             mode_o,
    output logic             im_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] preset_o,
    output logic [CNT_W-1:0] count_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic             mode_q, mode_d;
    logic             im_q, im_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            mode_q  <= 1'b0;
            im_q    <= 1'b0;
            pend_q  <= 1'b0;
            pre_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            im_q    <= im_d;
            pend_q  <= pend_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        mode_d  = mode_q;
        im_d    = im_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        case (state_q)
            S_IDLE: if (en_q) state_d = S_LOAD;
            S_LOAD: begin
                cnt_d   = pre_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                // Disable wins over expiry so a stopped timer never raises pending.
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    expire  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (mode_q) begin
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ctrl_we_i) begin
            en_d   = ctrl_wd_i[0];
            mode_d = ctrl_wd_i[1];
            im_d   = ctrl_wd_i[2];
        end
        if (preset_we_i) pre_d = preset_wd_i;
    end

    // Expiry on the same edge as a W1C keeps pending set.
    assign pend_d = expire | (pend_q & ~(status_we_i & w1c_i));

    assign en_o      = en_q;
    assign mode_o    = mode_q;
    assign im_o      = im_q;
    assign pending_o = pend_q;
    assign preset_o  = pre_q;
    assign count_o   = cnt_q;
endmodule

module timer_bank #(
    parameter int          N_CH      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00,
    parameter int          CNT_W     = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,     // asynchronous, active low
    input  logic [29:0]     addr_i,
    input  logic            we_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic            hit_o,
    output logic [N_CH-1:0] irq_o,
    output logic            irq_any_o
);
    localparam logic [31:0] WIN_BYTES = 32'(16 * N_CH);

    logic [31:0]                byte_addr;
    logic [31:0]                win_off;
    logic [1:0]                 word;
    logic [N_CH-1:0]            sel;
    logic [N_CH-1:0]            ch_en, ch_mode, ch_im, ch_pend;
    logic [N_CH-1:0][CNT_W-1:0] ch_preset, ch_count;

    // Offset from the window base; below-base addresses wrap high and fail the size check too.
    assign byte_addr = {addr_i, 2'b00};
    assign win_off   = byte_addr - BASE_ADDR;
    assign hit_o     = (byte_addr >= BASE_ADDR) && (win_off < WIN_BYTES);
    assign word      = win_off[3:2];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign sel[i] = hit_o && (win_off[31:4] == 28'(i));

        timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .ctrl_we_i   (we_i & sel[i] & (word == 2'd0)),
            .preset_we_i (we_i & sel[i] & (word == 2'd1)),
            .status_we_i (we_i & sel[i] & (word == 2'd3)),
            .ctrl_wd_i   ({wdata_i[3], wdata_i[1], wdata_i[0]}),
            .w1c_i       (wdata_i[0]),
            .preset_wd_i (wdata_i[CNT_W-1:0]),
            .en_o        (ch_en[i]),
            .mode_o      (ch_mode[i]),
            .im_o        (ch_im[i]),
            .pending_o   (ch_pend[i]),
            .preset_o    (ch_preset[i]),
            .count_o     (ch_count[i])
        );
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel[i]) begin
                case (word)
                    2'd0:    rdata_o = {28'd0, ch_im[i], 1'b0, ch_mode[i], ch_en[i]};
                    2'd1:    rdata_o = 32'(ch_preset[i]);
                    2'd2:    rdata_o = 32'(ch_count[i]);
                    default: rdata_o = {31'd0, ch_pend[i]};
                endcase
            end
        end
    end

    assign irq_o     = ch_pend & ch_im;
    assign irq_any_o = |irq_o;
endmodule

// File: tb/tb_timer_bank.sv
// Directed and randomized checks of timer_bank against an event-time reference model:
// each run is described by its load edge, loaded preset and resulting expiry edge.

module tb_timer_bank;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0000_7f00;

    logic          clk;
    logic          reset;
    logic [29:0]   addr;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          hit;
    logic [N-1:0]  irq;
    logic          irq_any;

    int n_cmp, n_bad, ecnt;

    // Reference state: architectural registers plus run timing (edge numbers, -1 = none).
    logic        m_en[N], m_mode[N], m_im[N], m_pend[N], m_run[N];
    logic [31:0] m_pre[N], m_cnt[N], m_p[N];
    int          m_L[N], m_E[N], m_dis[N];

    timer_bank #(.N_CH(N), .BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .addr_i    (addr),
        .we_i      (we),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .hit_o     (hit),
        .irq_o     (irq),
        .irq_any_o (irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0h, expected %0h", tag, ecnt, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: timeout, observed no event, expected event within bound", tag);
    endtask

    function automatic logic [29:0] wa(input int ch, input int off);
        logic [31:0] b;
        b = BASE + 32'(16 * ch + 4 * off);
        return b[31:2];
    endfunction

    function automatic void dec(input logic [29:0] a, output bit inwin, output int ch, output int off);
        logic [31:0] b, o;
        b     = {a, 2'b00};
        o     = b - BASE;
        inwin = (b >= BASE) && (o < 32'(16 * N));
        ch    = int'(o >> 4);
        off   = int'((o >> 2) & 32'd3);
    endfunction

    function automatic logic [29:0] oob_addr();
        case ($urandom_range(0, 3))
            0:       return wa(N, 0);
            1:       return wa(N + 1, 2);
            2:       return wa(-1, 3);
            default: return 30'h0;
        endcase
    endfunction

    function automatic logic [29:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return oob_addr();
        return wa($urandom_range(0, N - 1), $urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [29:0] a);
        bit w;
        int ch, off;
        dec(a, w, ch, off);
        if (!w) return 32'd0;
        case (off)
            0:       return {28'd0, m_im[ch], 1'b0, m_mode[ch], m_en[ch]};
            1:       return m_pre[ch];
            2:       return m_cnt[ch];
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    function automatic logic [N-1:0] exp_irq();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = m_pend[c] & m_im[c];
        return r;
    endfunction

    // CTRL writes are issued only when idle or while counting, where the outcome is unambiguous.
    function automatic bit ctrl_ok(input int c);
        int e;
        e = ecnt + 1;
        if (m_dis[c] != -1) return 1'b0;
        if (!m_run[c]) return !m_en[c];
        return (m_E[c] != -1) && (e >= m_L[c]) && (e <= m_E[c] - 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            m_pre[c] = 0; m_cnt[c] = 0; m_p[c] = 0;
            m_L[c] = -1; m_E[c] = -1; m_dis[c] = -1;
        end
    endtask

    task automatic model_edge(input bit wr, input int ch, input int off, input logic [31:0] d);
        bit sn[N];
        int e;
        e = ecnt;
        for (int c = 0; c < N; c++) begin
            sn[c] = 1'b0;
            if (m_run[c]) begin
                if (m_dis[c] == e) begin
                    m_run[c] = 0;
                    m_dis[c] = -1;
                end else if (e == m_L[c]) begin
                    m_p[c]   = m_pre[c];
                    m_cnt[c] = m_pre[c];
                    m_E[c]   = e + ((m_pre[c] == 0) ? 1 : int'(m_pre[c]));
                end else if (m_E[c] != -1 && e > m_L[c] && e < m_E[c]) begin
                    m_cnt[c] = m_p[c] - 32'(e - m_L[c]);
                end else if (e == m_E[c]) begin
                    m_cnt[c]  = 0;
                    m_pend[c] = 1;
                    sn[c]     = 1'b1;
                end else if (m_E[c] != -1 && e == m_E[c] + 1) begin
                    if (m_mode[c]) begin
                        m_L[c] = e + 1;
                        m_E[c] = -1;
                    end else begin
                        m_en[c]  = 0;
                        m_run[c] = 0;
                    end
                end
            end
        end
        if (wr) begin
            case (off)
                0: begin
                    if (d[0] && !m_en[ch] && !m_run[ch]) begin
                        m_run[ch] = 1;
                        m_L[ch]   = e + 2;
                        m_E[ch]   = -1;
                    end else if (!d[0] && m_en[ch] && m_run[ch]) begin
                        m_dis[ch] = e + 1;
                    end
                    m_en[ch] = d[0]; m_mode[ch] = d[1]; m_im[ch] = d[3];
                end
                1: m_pre[ch] = d;
                3: if (d[0] && !sn[ch]) m_pend[ch] = 0;
                default: ;
            endcase
        end
    endtask

    task automatic rd_chk(input logic [29:0] a);
        bit w;
        int ch, off;
        dec(a, w, ch, off);
        addr = a;
        #1;
        chk("rdata", rdata, exp_rd(a));
        chk("hit", 32'(hit), 32'(w));
    endtask

    task automatic rd_const(input logic [29:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic step(input bit wr, input logic [29:0] a, input logic [31:0] d);
        bit w;
        int ch, off;
        dec(a, w, ch, off);
        we = wr; addr = a; wdata = d;
        @(posedge clk);
        ecnt++;
        model_edge(wr && w, ch, off, d);
        #1;
        we = 1'b0;
        chk("irq", 32'(irq), 32'(exp_irq()));
        chk("irq_any", 32'(irq_any), 32'(exp_irq() != '0));
        rd_chk(rand_addr());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, rand_addr(), $urandom);
    endtask

    task automatic wait_cnt(input int c, input logic [31:0] v, input string tag);
        int k;
        k = 0;
        while (!(m_run[c] && m_cnt[c] == v) && k < 300) begin idle(1); k++; end
        if (k >= 300) tmo(tag);
    endtask

    task automatic wait_ok(input int c, input string tag);
        int k;
        k = 0;
        while (!ctrl_ok(c) && k < 300) begin idle(1); k++; end
        if (k >= 300) tmo(tag);
    endtask

    task automatic wait_exp(input int c, input string tag);
        int k;
        k = 0;
        while (!(m_run[c] && m_E[c] == ecnt + 1) && k < 300) begin idle(1); k++; end
        if (k >= 300) tmo(tag);
    endtask

    initial begin
        int          op, c;
        logic [31:0] d;
        n_cmp = 0; n_bad = 0; ecnt = 0;
        we = 0; addr = '0; wdata = '0; reset = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_irq_any", 32'(irq_any), 0);
        rd_const(wa(0, 2), 0, "rst_count");
        rd_const(wa(3, 0), 0, "rst_ctrl");
        reset = 1'b1;

        // One-shot on ch0: PRESET=5, start at edge 0, pending at edge 7
        step(1, wa(0, 1), 32'd5);
        step(1, wa(0, 0), 32'h9);
        idle(6);
        chk("os_before", 32'(irq[0]), 0);
        idle(1);
        chk("os_edge7", 32'(irq[0]), 1);
        idle(1);
        rd_const(wa(0, 0), 32'h8, "os_en_clr");
        rd_const(wa(0, 2), 0, "os_cnt0");
        step(1, wa(0, 2), 32'h1234);
        rd_const(wa(0, 2), 0, "count_ro");
        step(1, wa(0, 3), 32'h1);
        chk("os_w1c", 32'(irq[0]), 0);

        // Out-of-window access
        step(1, wa(N, 0), 32'hF);
        rd_const(wa(N, 0), 0, "oob_rdata");
        chk("oob_hit", 32'(hit), 0);

        // Auto-reload on ch2: PRESET=3, period 5; W1C on an expiry edge loses
        step(1, wa(2, 1), 32'd3);
        step(1, wa(2, 0), 32'hB);
        wait_exp(2, "ar_wait");
        step(1, wa(2, 3), 32'h1);
        chk("ar_set_wins", 32'(irq[2]), 1);
        step(1, wa(2, 3), 32'h1);
        chk("ar_cleared", 32'(irq[2]), 0);
        idle(3);
        chk("ar_not_yet", 32'(irq[2]), 0);
        idle(1);
        chk("ar_period5", 32'(irq[2]), 1);
        wait_ok(2, "ar_stop");
        step(1, wa(2, 0), 32'h0);

        // Masking on ch1
        step(1, wa(1, 1), 32'd2);
        step(1, wa(1, 0), 32'h1);
        idle(4);
        rd_const(wa(1, 3), 1, "mk_pending");
        chk("mk_masked", 32'(irq[1]), 0);
        idle(1);
        step(1, wa(1, 0), 32'h9);
        chk("mk_unmask", 32'(irq[1]), 1);
        step(1, wa(1, 3), 32'h1);
        chk("mk_w1c", 32'(irq[1]), 0);

        // Mid-count PRESET edit on ch3 leaves the current run alone
        step(1, wa(3, 1), 32'd12);
        step(1, wa(3, 0), 32'h9);
        wait_cnt(3, 32'd6, "mc_wait");
        step(1, wa(3, 1), 32'd4);
        rd_const(wa(3, 2), 32'd5, "mc_keep");
        rd_const(wa(3, 1), 32'd4, "mc_preset");
        idle(4);
        chk("mc_not_yet", 32'(irq[3]), 0);
        idle(1);
        chk("mc_expire", 32'(irq[3]), 1);
        step(1, wa(3, 3), 32'h1);

        // Disable mid-count freezes COUNT
        wait_ok(3, "dis_ready");
        step(1, wa(3, 1), 32'd30);
        step(1, wa(3, 0), 32'h9);
        wait_cnt(3, 32'd20, "dis_wait");
        step(1, wa(3, 0), 32'h0);
        idle(3);
        rd_const(wa(3, 2), 32'd19, "dis_frozen");
        chk("dis_no_irq", 32'(irq[3]), 0);

        // Reset mid-count
        step(1, wa(0, 1), 32'd50);
        step(1, wa(0, 0), 32'h9);
        idle(8);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_irq", 32'(irq), 0);
        chk("mrst_irq_any", 32'(irq_any), 0);
        rd_const(wa(0, 2), 0, "mrst_count");
        rd_const(wa(0, 1), 0, "mrst_preset");
        model_reset();
        reset = 1'b1;

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            op = $urandom_range(0, 9);
            c  = $urandom_range(0, N - 1);
            d  = $urandom;
            case (op)
                0, 1, 2: begin
                    if (ctrl_ok(c)) begin
                        d[0] = m_run[c] ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) != 0);
                        step(1, wa(c, 0), d);
                    end else begin
                        step(0, wa(c, 0), d);
                    end
                end
                3, 4: step(1, wa(c, 1), ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 200))
                                                                     : 32'($urandom_range(0, 10)));
                5: step(1, wa(c, 3), d);
                6: step(1, wa(c, 2), d);
                7: step(1, oob_addr(), d);
                default: step(0, rand_addr(), d);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
